// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue sequencer: widths, opcodes, FSM states
// and the layout of a buffered command.
package alu_issue_pkg;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // One buffered command; acc selects the accumulator in place of operand A.
  typedef struct packed {
    logic         acc;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the command port, the ALU drive/answer signals and the result port.
// slave is the issue sequencer; master is the surrounding environment that
// issues commands, hosts the ALU and consumes results.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic             cmd_acc;

  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [1:0]       alu_op;
  logic [W-1:0]     alu_ans;

  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_data;

  logic [CNT_W-1:0] count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, alu_ans, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, alu_ans, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, count
  );

endinterface

// File: rtl/alu_issue_cmd_fifo.sv
// Small synchronous command FIFO. The head entry is always visible on dout_o
// so the consumer can load from it on the same edge it pops.
module alu_issue_cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 10,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wrPtr_q] <= din_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_issue.sv
// Command buffer and issue sequencer feeding an external 4-bit combinational ALU.
// Commands are queued, issued one at a time through registered ALU operands,
// and each answer is held on the result port until the consumer takes it.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);

  state_e           state_q;
  logic [W-1:0]     aluA_q;
  logic [W-1:0]     aluB_q;
  logic [1:0]       aluOp_q;
  logic             resValid_q;
  logic [W-1:0]     resData_q;
  logic [W-1:0]     accReg_q;

  logic [CNT_W-1:0] fifoCount;
  cmd_t             cmdIn;
  cmd_t             headCmd;
  logic             pushEn;
  logic             popEn;

  assign cmdIn = '{acc: bus.cmd_acc, op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};

  // Ready depends only on the registered occupancy, so a push while full cannot happen.
  assign bus.cmd_ready = (fifoCount < CNT_W'(DEPTH));
  assign pushEn        = bus.cmd_valid && bus.cmd_ready;

  // Pop from IDLE, or on the result handshake edge so back-to-back results need two cycles.
  assign popEn = (fifoCount != '0) &&
                 ((state_q == IDLE) || ((state_q == HOLD) && bus.res_ready));

  alu_issue_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .din_i   (cmdIn),
    .dout_o  (headCmd),
    .count_o (fifoCount)
  );

  // Issue FSM: load operands on pop, capture the answer one cycle later, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluOp_q    <= OP_AND;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      accReg_q   <= '0;
    end else begin
      if (popEn) begin
        aluA_q  <= headCmd.acc ? accReg_q : headCmd.a;
        aluB_q  <= headCmd.b;
        aluOp_q <= headCmd.op;
      end
      case (state_q)
        IDLE: begin
          if (popEn) begin
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          resData_q  <= bus.alu_ans;
          accReg_q   <= bus.alu_ans;
          resValid_q <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            resValid_q <= 1'b0;
            state_q    <= popEn ? ISSUE : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a     = aluA_q;
  assign bus.alu_b     = aluB_q;
  assign bus.alu_op    = aluOp_q;
  assign bus.res_valid = resValid_q;
  assign bus.res_data  = resData_q;
  assign bus.count     = fifoCount;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: hosts a behavioural ALU, drives directed and random
// command traffic, and compares results against an in-order reference model.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_issue_if bus();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 4-bit ALU sitting downstream of the sequencer.
  always_comb begin
    case (bus.alu_op)
      2'b00:   bus.alu_ans = bus.alu_a & bus.alu_b;
      2'b01:   bus.alu_ans = bus.alu_a | bus.alu_b;
      2'b10:   bus.alu_ans = bus.alu_a ^ bus.alu_b;
      default: bus.alu_ans = bus.alu_a + bus.alu_b;
    endcase
  end

  int checkCount = 0;
  int passCount  = 0;
  int expQ[$];
  int obsLog[$];
  int accModel   = 0;
  bit holdPending = 1'b0;
  int heldData   = 0;
  bit randDone   = 1'b0;

  // Results are produced in command order and each result becomes the next accumulator.
  function automatic int refResult(input int op, input int a, input int b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return (a + b) % 16;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Mid-cycle monitor: predicts accepted commands and checks every result handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      accModel    = 0;
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("resValidHeld", int'(bus.res_valid), 1);
        checkOutput("resDataHeld", int'(bus.res_data), heldData);
      end
      if (bus.res_valid && bus.res_ready) begin
        holdPending = 1'b0;
        obsLog.push_back(int'(bus.res_data));
        if (expQ.size() == 0) checkOutput("resUnexpected", 1, 0);
        else checkOutput("resData", int'(bus.res_data), expQ.pop_front());
      end else if (bus.res_valid) begin
        holdPending = 1'b1;
        heldData    = int'(bus.res_data);
      end else begin
        holdPending = 1'b0;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        int r;
        r = refResult(int'(bus.cmd_op), bus.cmd_acc ? accModel : int'(bus.cmd_a), int'(bus.cmd_b));
        expQ.push_back(r);
        accModel = r;
      end
    end
  end

  // Presents one command and holds it until an edge accepts it.
  task automatic applyStimulus(input logic acc, input logic [1:0] op,
                               input logic [3:0] a, input logic [3:0] b);
    int  n = 0;
    bit  accepted = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_acc   = acc;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    while (!accepted && n < 200) begin
      @(negedge clk);
      accepted = bus.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!accepted) checkOutput("pushTimeout", 0, 1);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitResValid(input string tag);
    int n = 0;
    while (!bus.res_valid && n < 50) begin
      stepCycle();
      n++;
    end
    if (!bus.res_valid) checkOutput(tag, 0, 1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || bus.res_valid || bus.count != 0) && n < 500) begin
      stepCycle();
      n++;
    end
    if (expQ.size() != 0 || bus.res_valid) checkOutput("drainTimeout", 0, 1);
  endtask

  initial begin
    int base;
    int heldD;
    bus.cmd_valid = 1'b0;
    bus.cmd_acc   = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state.
    #3;
    checkOutput("rstCount", int'(bus.count), 0);
    checkOutput("rstResValid", int'(bus.res_valid), 0);
    checkOutput("rstCmdReady", int'(bus.cmd_ready), 1);
    checkOutput("rstAluOp", int'(bus.alu_op), 0);
    checkOutput("rstAluA", int'(bus.alu_a), 0);
    checkOutput("rstResData", int'(bus.res_data), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single ADD with carry dropped, and its latency.
    bus.res_ready = 1'b1;
    applyStimulus(1'b0, 2'b11, 4'd9, 4'd8);
    checkOutput("t1CountAfterPush", int'(bus.count), 1);
    stepCycle();
    checkOutput("t1ValidE1", int'(bus.res_valid), 0);
    checkOutput("t1AluA", int'(bus.alu_a), 9);
    checkOutput("t1AluB", int'(bus.alu_b), 8);
    checkOutput("t1AluOp", int'(bus.alu_op), 3);
    checkOutput("t1CountE1", int'(bus.count), 0);
    stepCycle();
    checkOutput("t1ValidE2", int'(bus.res_valid), 1);
    checkOutput("t1Data", int'(bus.res_data), 1);
    stepCycle();
    checkOutput("t1ValidAfterTake", int'(bus.res_valid), 0);
    checkOutput("t1CountEnd", int'(bus.count), 0);

    // Accumulate chain.
    base = obsLog.size();
    applyStimulus(1'b0, 2'b11, 4'h3, 4'h4);
    applyStimulus(1'b1, 2'b11, 4'h0, 4'hA);
    applyStimulus(1'b1, 2'b10, 4'h0, 4'hF);
    waitDrain();
    checkOutput("t2Len", obsLog.size() - base, 3);
    if (obsLog.size() - base == 3) begin
      checkOutput("t2Res0", obsLog[base], 7);
      checkOutput("t2Res1", obsLog[base+1], 1);
      checkOutput("t2Res2", obsLog[base+2], 14);
    end

    // Full backpressure across pointer wrap.
    base = obsLog.size();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    checkOutput("t3CountFull", int'(bus.count), 4);
    checkOutput("t3ReadyLow", int'(bus.cmd_ready), 0);
    checkOutput("t3ValidHeld", int'(bus.res_valid), 1);
    bus.res_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 4'h0, 4'h5);
    waitDrain();
    checkOutput("t3Len", obsLog.size() - base, 6);

    // Result stall with a push into the empty FIFO while holding.
    bus.res_ready = 1'b0;
    applyStimulus(1'b0, 2'b01, 4'h5, 4'hA);
    waitResValid("t4ValidTimeout");
    heldD = int'(bus.res_data);
    checkOutput("t4Data", heldD, 15);
    applyStimulus(1'b0, 2'b00, 4'hC, 4'h6);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("t4StallValid", int'(bus.res_valid), 1);
      checkOutput("t4StallData", int'(bus.res_data), heldD);
      checkOutput("t4StallCount", int'(bus.count), 1);
    end
    bus.res_ready = 1'b1;
    stepCycle();
    checkOutput("t4HsValid", int'(bus.res_valid), 0);
    checkOutput("t4HsCount", int'(bus.count), 0);
    checkOutput("t4HsAluA", int'(bus.alu_a), 12);
    checkOutput("t4HsAluB", int'(bus.alu_b), 6);
    checkOutput("t4HsAluOp", int'(bus.alu_op), 0);
    stepCycle();
    checkOutput("t4NextValid", int'(bus.res_valid), 1);
    checkOutput("t4NextData", int'(bus.res_data), 4);
    waitDrain();

    // Reset while in ISSUE with three commands buffered.
    bus.res_ready = 1'b0;
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h2);
    waitResValid("t5ValidTimeout");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    checkOutput("t5CountFull", int'(bus.count), 4);
    bus.res_ready = 1'b1;
    stepCycle();
    checkOutput("t5CountIssue", int'(bus.count), 3);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5RstCount", int'(bus.count), 0);
    checkOutput("t5RstValid", int'(bus.res_valid), 0);
    checkOutput("t5RstAluOp", int'(bus.alu_op), 0);
    checkOutput("t5RstReady", int'(bus.cmd_ready), 1);
    checkOutput("t5RstData", int'(bus.res_data), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    base = obsLog.size();
    applyStimulus(1'b1, 2'b11, 4'h5, 4'h6);
    waitDrain();
    checkOutput("t5AccLen", obsLog.size() - base, 1);
    if (obsLog.size() - base == 1) checkOutput("t5AccZero", obsLog[base], 6);

    // Random traffic with random consumer backpressure.
    base = obsLog.size();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) stepCycle();
          applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          stepCycle();
          bus.res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.res_ready = 1'b1;
    waitDrain();
    checkOutput("t6Len", obsLog.size() - base, 40);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Command buffer and issue sequencer that sits directly upstream of the 4-bit combinational ALU (AND/OR/XOR/ADD).
It accepts operation commands over a valid/ready port, buffers them in a small FIFO, and drives the ALU operand and opcode inputs from registers.
It captures the ALU answer and presents it on a valid/ready result port.
An accumulate mode substitutes the previous result for operand A, so the block can chain ALU operations.

## Interface
- DEPTH, 4, command FIFO entries; must be a power of two, at least 2.
- W, 4, datapath width; fixed at 4 to match the ALU.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  FIFO can accept a command; high when count < DEPTH.
- cmd_op  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 ADD.
- cmd_a  in  W  operand A; ignored when cmd_acc = 1.
- cmd_b  in  W  operand B.
- cmd_acc  in  1  when 1, operand A is the accumulator (the last captured result).
- alu_a  out  W  registered operand A to the ALU.
- alu_b  out  W  registered operand B to the ALU.
- alu_op  out  2  registered opcode to the ALU.
- alu_ans  in  W  combinational ALU answer.
- res_valid  out  1  result is held on res_data.
- res_ready  in  1  consumer accepts the result.
- res_data  out  W  captured ALU answer.
- count  out  clog2(DEPTH)+1  number of commands currently buffered.

## Operation
- Push: when cmd_valid and cmd_ready are both high at an edge, {cmd_acc, cmd_op, cmd_a, cmd_b} is written at wr_ptr. wr_ptr then increments modulo DEPTH.
- Pop: reads the entry at rd_ptr, then increments rd_ptr modulo DEPTH.
- Pointers wrap silently. count increments on push only, decrements on pop only, and is unchanged when a push and a pop occur in the same cycle.
- cmd_ready is derived from the registered count only. There is no combinational path from res_ready or cmd_valid to cmd_ready. A push while full is impossible.
- State machine, with states IDLE, ISSUE and HOLD:
  - IDLE: if count > 0, pop the head entry and load alu_a/alu_b/alu_op, then go to ISSUE. Otherwise stay in IDLE.
  - Operand A at load: alu_a is loaded with acc_reg if the entry's acc bit is 1, and with the stored A otherwise.
  - ISSUE: on one cycle only, capture alu_ans into res_data and into acc_reg, set res_valid, and go to HOLD.
  - HOLD: res_valid stays high and res_data stays stable until res_ready = 1.
  - On the HOLD handshake edge, res_valid clears. If count > 0, pop and load the ALU registers on the same edge and go to ISSUE; otherwise go to IDLE.
- Accumulator behaviour: acc_reg is updated only at ISSUE, before the next pop. A chain of acc commands therefore always sees the immediately preceding result.
- Arithmetic: the ALU ADD result is modulo 2^W and the carry is discarded. This block does no arithmetic itself.
- alu_* hold their last values between operations; they are not cleared in IDLE.
- Simultaneous events:
  - A push into an empty FIFO is not visible to IDLE until the next edge, because the pop decision uses the registered count.
  - A push and a pop in the same cycle are both honoured.
- Reset (asserted at any time, including mid-operation) forces:
  - state = IDLE, wr_ptr = rd_ptr = count = 0;
  - res_valid = 0, res_data = 0, acc_reg = 0;
  - alu_a = alu_b = 0, alu_op = 00, cmd_ready = 1.
  - Buffered and in-flight commands are discarded.

## Timing
- Latency, with command accepted at edge E0, FIFO previously empty and state IDLE:
  - E1: pop; alu_* registered.
  - E2: result captured; res_valid high after E2.
- Minimum spacing is 2 cycles per result when res_ready is held high: ISSUE, then HOLD with the handshake and pop on the same edge.
- res_data is stable for the whole time res_valid is high. res_valid never drops without a handshake, except on reset.
- The ALU is combinational and must settle within one cycle of alu_* changing.

## Structure
- Shared package/header: opcode constants OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_ADD = 2'b11, and the state encodings IDLE/ISSUE/HOLD.
- One sub-module: cmd_fifo, a DEPTH-entry synchronous FIFO.
  - Width 1+2+2W.
  - Ports: push/pop/dout/count.
  - Asynchronous active-low reset.
- The FSM, the ALU operand registers and the result registers live in alu_issue.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Single command: op=11, a=9, b=8, with res_ready=1 → res_valid rises 2 edges after accept, res_data = 1 (carry dropped), count returns to 0.
- Accumulate chain: (op=11, a=3, b=4), then (acc, op=11, b=A), then (acc, op=10, b=F) → res_data sequence 7, 1, E.
- Full backpressure: res_ready=0; push 6 commands back-to-back → cmd_ready falls after the FIFO is full and one command is in HOLD. Release res_ready → all results appear in order, with no loss or duplication across pointer wrap.
- Result stall: hold res_ready=0 for 5 cycles in HOLD → res_valid and res_data stay stable; the next pop occurs only on the handshake edge.
- Push into empty FIFO while a result waits in HOLD, then assert res_ready → handshake and pop on the same edge, next result 2 cycles later.
- Reset mid-operation: assert rst_n=0 in ISSUE with 3 commands buffered → immediately count = 0, res_valid = 0, alu_op = 00, cmd_ready = 1. After release, an acc command uses acc_reg = 0.
